muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit for all eight M-extension operations.
- Sits beside the ALU in the execute stage. The core issues an operation with a start pulse and stalls on op_busy.
- An internal FSM sequences a shared 32-step shift-add / restoring-subtract datapath, then writes back through op_result/op_valid.
- Handles the RISC-V divide-by-zero and signed-overflow cases without iterating.

---
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/writeback bundle between the execute stage
// and the iterative multiply/divide unit.
//   master : core side, drives the request (start, kill, funct3, operands, tag)
//            and observes result, tag, valid strobe and busy.
//   slave  : the multiply/divide unit.
interface muldiv_sequencer_if #(
  parameter int size = 32
);
  logic            ip_start;
  logic            ip_kill;
  logic [2:0]      ip_funct3;
  logic [size-1:0] ip_rs1;
  logic [size-1:0] ip_rs2;
  logic [4:0]      ip_rd_addr;
  logic [size-1:0] op_result;
  logic [4:0]      op_rd_addr;
  logic            op_valid;
  logic            op_busy;

  modport master (
    output ip_start, ip_kill, ip_funct3, ip_rs1, ip_rs2, ip_rd_addr,
    input  op_result, op_rd_addr, op_valid, op_busy
  );

  modport slave (
    input  ip_start, ip_kill, ip_funct3, ip_rs1, ip_rs2, ip_rd_addr,
    output op_result, op_rd_addr, op_valid, op_busy
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit.
// One shared 64-bit accumulator runs 32 shift-add (multiply) or
// restoring-subtract (divide) steps on operand magnitudes; the sign is
// applied afterwards in FIX. Divide-by-zero and signed overflow skip the
// iteration and go straight to DONE.
// Ports:
//   ip_clk  : clock, all state changes on the rising edge
//   ip_rst  : synchronous active-high reset, overrides everything
//   bus     : slave side of muldiv_sequencer_if
//             ip_start/ip_kill/ip_funct3/ip_rs1/ip_rs2/ip_rd_addr in,
//             op_result/op_rd_addr/op_valid/op_busy out
module muldiv_sequencer #(
  parameter int size      = 32,
  parameter int cnt_width = 5
) (
  input  logic               ip_clk,
  input  logic               ip_rst,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(size - 1);
  localparam logic [size-1:0]      min_int  = {1'b1, {(size-1){1'b0}}};

  state_t                 state_reg, state_next;
  logic [2:0]             funct3_reg;
  logic [4:0]             rd_addr_reg;
  logic [size-1:0]        operand_reg;   // multiplicand (mul) or divisor (div)
  logic [2*size-1:0]      acc_reg;       // {hi, lo} product or {rem, quot}
  logic [cnt_width-1:0]   cnt_reg;
  logic                   sign_reg;      // negate the selected result in FIX
  logic [size-1:0]        result_reg;

  // Request decode, only meaningful in IDLE.
  logic            is_div, a_signed, b_signed, sign_a, sign_b;
  logic [size-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special, accept;
  logic [size-1:0] special_val;

  assign is_div   = bus.ip_funct3[2];
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  assign a_signed = is_div ? ~bus.ip_funct3[0] : (bus.ip_funct3[1] ^ bus.ip_funct3[0]);
  assign b_signed = is_div ? ~bus.ip_funct3[0] : (bus.ip_funct3[1:0] == 2'b01);
  assign sign_a   = a_signed & bus.ip_rs1[size-1];
  assign sign_b   = b_signed & bus.ip_rs2[size-1];
  assign abs_a    = sign_a ? -bus.ip_rs1 : bus.ip_rs1;
  assign abs_b    = sign_b ? -bus.ip_rs2 : bus.ip_rs2;

  assign div_zero = is_div & (bus.ip_rs2 == '0);
  assign div_ovf  = is_div & ~bus.ip_funct3[0] & (bus.ip_rs1 == min_int) & (bus.ip_rs2 == '1);
  assign special  = div_zero | div_ovf;
  assign accept   = (state_reg == IDLE) & bus.ip_start & ~bus.ip_kill;

  // funct3[1] distinguishes REM* from DIV*.
  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = bus.ip_funct3[1] ? bus.ip_rs1 : '1;
    else
      special_val = bus.ip_funct3[1] ? '0 : min_int;
  end

  // One multiply step: conditional add into the upper half, keeping the
  // carry so the 64-bit right shift brings it in at the top.
  logic [size:0]     mul_upper;
  logic [2*size-1:0] mul_step;
  assign mul_upper = acc_reg[0] ? ({1'b0, acc_reg[2*size-1:size]} + {1'b0, operand_reg})
                                : {1'b0, acc_reg[2*size-1:size]};
  assign mul_step  = {mul_upper, acc_reg[size-1:1]};

  // One restoring divide step: the shifted remainder needs size+1 bits.
  // When the trial succeeds the difference is below the divisor, so the
  // low size bits of the subtraction are exact.
  logic [size:0]     rem_shift;
  logic              div_ge;
  logic [size-1:0]   div_diff;
  logic [2*size-1:0] div_step;
  assign rem_shift = acc_reg[2*size-1:size-1];
  assign div_ge    = rem_shift >= {1'b0, operand_reg};
  assign div_diff  = rem_shift[size-1:0] - operand_reg;
  assign div_step  = {div_ge ? div_diff : rem_shift[size-1:0], acc_reg[size-2:0], div_ge};

  // Sign fix-up and output selection.
  logic [2*size-1:0] prod_fix;
  logic [size-1:0]   div_raw, div_fix, fix_val;
  assign prod_fix = sign_reg ? -acc_reg : acc_reg;
  assign div_raw  = funct3_reg[1] ? acc_reg[2*size-1:size] : acc_reg[size-1:0];
  assign div_fix  = sign_reg ? -div_raw : div_raw;
  always_comb begin
    fix_val = div_fix;
    if (!funct3_reg[2])
      fix_val = (funct3_reg[1:0] == 2'b00) ? prod_fix[size-1:0] : prod_fix[2*size-1:size];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (bus.ip_kill)            state_next = IDLE;
        else if (cnt_reg == cnt_last) state_next = FIX;
      end
      FIX:  state_next = bus.ip_kill ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      funct3_reg  <= '0;
      rd_addr_reg <= '0;
      operand_reg <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      sign_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          funct3_reg  <= bus.ip_funct3;
          rd_addr_reg <= bus.ip_rd_addr;
          cnt_reg     <= '0;
          // Remainder takes the dividend's sign; product and quotient the xor.
          sign_reg    <= (is_div & bus.ip_funct3[1]) ? sign_a : (sign_a ^ sign_b);
          operand_reg <= is_div ? abs_b : abs_a;
          acc_reg     <= {{size{1'b0}}, is_div ? abs_a : abs_b};
          if (special) result_reg <= special_val;
        end
        CALC: if (!bus.ip_kill) begin
          acc_reg <= funct3_reg[2] ? div_step : mul_step;
          cnt_reg <= cnt_reg + cnt_width'(1);
        end
        FIX: if (!bus.ip_kill) result_reg <= fix_val;
        default: ;
      endcase
    end
  end

  assign bus.op_result  = result_reg;
  assign bus.op_rd_addr = rd_addr_reg;
  assign bus.op_valid   = (state_reg == DONE) & ~bus.ip_kill;
  assign bus.op_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed stimulus for muldiv_sequencer,
// checked every cycle against a timing/arithmetic model derived from the
// RV32M rules (64-bit arithmetic, fixed 34-cycle / 1-cycle busy windows).
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.size(32)) bus();

  muldiv_sequencer #(.size(32), .cnt_width(5)) dut (
    .ip_clk(clk),
    .ip_rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: busy window [m_first, m_last], valid at m_last.
  bit          m_active = 0;
  int          m_first = 0, m_last = -1;
  logic [31:0] m_res = '0, m_prev = '0;
  logic [4:0]  m_tag = '0;
  bit          kill_now = 0;
  bit          cmp_en = 0;
  int          busy_cnt = 0, valid_cnt = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_tag = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic bit model_busy(input int c);
    return m_active && c >= m_first && c <= m_last;
  endfunction

  // Per-cycle comparison against the model.
  logic        e_busy, e_valid;
  logic [31:0] e_res;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_busy  = model_busy(cyc);
      e_valid = e_busy && (cyc == m_last) && !kill_now;
      e_res   = (m_active && cyc >= m_last) ? m_res : m_prev;
      chk("op_busy", {31'b0, bus.op_busy}, {31'b0, e_busy});
      chk("op_valid", {31'b0, bus.op_valid}, {31'b0, e_valid});
      chk("op_result", bus.op_result, e_res);
      chk("op_rd_addr", {27'b0, bus.op_rd_addr}, {27'b0, m_tag});
      if (bus.op_busy === 1'b1) busy_cnt++;
      if (bus.op_valid === 1'b1) begin
        valid_cnt++;
        last_res = bus.op_result;
        last_tag = bus.op_rd_addr;
      end
    end
  end

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; the model decides acceptance itself.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit with_kill);
    bit idle;
    bus.ip_funct3  = f;
    bus.ip_rs1     = a;
    bus.ip_rs2     = b;
    bus.ip_rd_addr = tag;
    bus.ip_start   = 1'b1;
    bus.ip_kill    = with_kill;
    kill_now       = with_kill;
    idle = !model_busy(cyc);
    step_edge();
    bus.ip_start   = 1'b0;
    bus.ip_kill    = 1'b0;
    kill_now       = 0;
    // Scramble operands after the request; they must not matter any more.
    bus.ip_rs1     = $urandom;
    bus.ip_rs2     = $urandom;
    bus.ip_funct3  = 3'($urandom_range(0, 7));
    bus.ip_rd_addr = 5'($urandom_range(0, 31));
    if (idle && !with_kill) begin
      if (m_active) m_prev = m_res;
      m_active = 1;
      m_first  = cyc;
      m_last   = cyc + (is_special(f, a, b) ? 0 : 33);
      m_res    = ref_op(f, a, b);
      m_tag    = tag;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && bus.op_busy !== 1'b0; i++) step_edge();
    if (bus.op_busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL timeout cyc=%0d op_busy=%b required=0", cyc, bus.op_busy);
    end
  endtask

  task automatic kill_after(input int off);
    int k;
    repeat (off) step_edge();
    bus.ip_kill = 1'b1;
    kill_now    = 1;
    k = cyc;
    step_edge();
    bus.ip_kill = 1'b0;
    kill_now    = 0;
    if (k < m_last) m_active = 0;
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] lit,
                          input int busy_len);
    int v0;
    chk({name, "_model"}, ref_op(f, a, b), lit);
    v0 = valid_cnt;
    busy_cnt = 0;
    issue(f, a, b, tag, 0);
    wait_idle();
    chk({name, "_result"}, last_res, lit);
    chk({name, "_tag"}, {27'b0, last_tag}, {27'b0, tag});
    chk({name, "_nvalid"}, 32'(valid_cnt - v0), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_len));
    $display("op %s f=%0d a=%h b=%h tag=%0d result=%h", name, f, a, b, tag, last_res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int v0, gap;
    logic [2:0] f;
    logic [31:0] a, b, prev;
    logic [4:0] tag;
    bus.ip_start = 0; bus.ip_kill = 0; bus.ip_funct3 = 0;
    bus.ip_rs1 = 0; bus.ip_rs2 = 0; bus.ip_rd_addr = 0;
    repeat (3) step_edge();
    rst = 1'b0;
    chk("reset_result", bus.op_result, 32'h0);
    chk("reset_tag", {27'b0, bus.op_rd_addr}, 32'h0);
    chk("reset_valid_busy", {30'b0, bus.op_valid, bus.op_busy}, 32'h0);
    cmp_en = 1;

    directed("mul",    3'd0, 32'h7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34);
    directed("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 34);
    directed("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 34);
    directed("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34);
    directed("div",    3'd4, 32'hFFFFFFF9, 32'h2,        5'd5,  32'hFFFFFFFD, 34);
    directed("rem",    3'd6, 32'hFFFFFFF9, 32'h2,        5'd6,  32'hFFFFFFFF, 34);
    directed("divu",   3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       34);
    directed("remu",   3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        34);
    directed("divu_z", 3'd5, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
    directed("rem_z",  3'd6, 32'd5,        32'd0,        5'd10, 32'd5,        1);
    directed("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
    directed("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0,        1);

    // Kill at iteration 10, then a new op in the very next IDLE cycle.
    prev = bus.op_result;
    v0 = valid_cnt;
    issue(3'd0, 32'd1234, 32'd5678, 5'd20, 0);
    kill_after(10);
    chk("kill_busy", {31'b0, bus.op_busy}, 32'h0);
    chk("kill_result", bus.op_result, prev);
    directed("after_kill", 3'd5, 32'd1000, 32'd3, 5'd21, 32'd333, 34);
    chk("kill_nvalid", 32'(valid_cnt - v0), 32'd1);
    $display("op kill_at_10 tag=20 suppressed");

    // Start while busy is ignored; only the original tag writes back.
    v0 = valid_cnt;
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd5, 0);
    repeat (5) step_edge();
    issue(3'd4, 32'd77, 32'd7, 5'd9, 0);
    wait_idle();
    chk("busy_start_nvalid", 32'(valid_cnt - v0), 32'd1);
    chk("busy_start_tag", {27'b0, last_tag}, 32'd5);
    $display("op ignored_start tag=%0d result=%h", last_tag, last_res);

    // start+kill together in IDLE is not accepted.
    issue(3'd0, 32'd3, 32'd3, 5'd30, 1);
    chk("start_kill_busy", {31'b0, bus.op_busy}, 32'h0);

    // Reset in the middle of CALC.
    issue(3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd17, 0);
    repeat (15) step_edge();
    rst = 1'b1;
    step_edge();
    m_active = 0; m_prev = '0; m_tag = '0;
    rst = 1'b0;
    chk("rst_result", bus.op_result, 32'h0);
    chk("rst_tag", {27'b0, bus.op_rd_addr}, 32'h0);
    chk("rst_valid_busy", {30'b0, bus.op_valid, bus.op_busy}, 32'h0);
    $display("op mid_calc_reset");

    // Randomized traffic with occasional kills and idle start+kill.
    for (int n = 0; n < 150; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      tag = 5'($urandom_range(0, 31));
      issue(f, a, b, tag, 0);
      if (!is_special(f, a, b) && $urandom_range(0, 7) == 0) begin
        gap = $urandom_range(0, 33);
        kill_after(gap);
        $display("op rand f=%0d a=%h b=%h tag=%0d killed_at=%0d", f, a, b, tag, gap);
      end else begin
        wait_idle();
        $display("op rand f=%0d a=%h b=%h tag=%0d result=%h", f, a, b, tag, bus.op_result);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) step_edge();
      if ($urandom_range(0, 9) == 0) issue(f, a, b, tag, 1);
    end

    repeat (3) step_edge();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
